nmi_dec_n: RTL and testbench
============================

Name: nmi_dec_n

Overview:
- Parametrised, registered successor of the native-IP address decoder: one NMI master port fans out to NUM_SLV NMI slave ports.
- Slave select comes from a base/mask address-map table.
- Adds behaviour the flat combinational decoder lacks:
  - transaction FSM with registered response
  - error response for unmapped addresses
  - per-transaction timeout counter
  - sticky error capture for sysctrl/irq.
- Sits between the core NMI bus and native peripherals (gpio, uart, timers, psram, spisd, i2c, i2s, onewire, qspi, dma, sysctrl).

Parameters:
- NUM_SLV, 12, number of slave ports (1..32)
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb width = DATA_W/8)
- SLV_BASE, {NUM_SLV{ADDR_W'h0}}, packed per-slave base addresses, slave i at [i*ADDR_W +: ADDR_W]
- SLV_MASK, {NUM_SLV{ADDR_W'h0}}, packed per-slave compare masks; hit_i = ((addr & MASK_i) == BASE_i)
- TIMEOUT, 1023, cycles in BUSY before abort; 0 disables timeout
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on error responses

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_valid_i  in  1  master request valid, held until m_ready_o
- m_addr_i  in  ADDR_W  master address
- m_wdata_i  in  DATA_W  write data
- m_wstrb_i  in  DATA_W/8  byte strobes; 0 = read
- m_ready_o  out  1  one-cycle response pulse
- m_rdata_o  out  DATA_W  registered response data
- m_err_o  out  1  qualifies m_ready_o as an error response
- s_valid_o  out  NUM_SLV  one-hot slave valid
- s_addr_o  out  ADDR_W  broadcast address (registered)
- s_wdata_o  out  DATA_W  broadcast write data (registered)
- s_wstrb_o  out  DATA_W/8  broadcast strobes (registered)
- s_ready_i  in  NUM_SLV  per-slave ready
- s_rdata_i  in  NUM_SLV*DATA_W  packed per-slave rdata
- err_vld_o  out  1  sticky error flag
- err_code_o  out  2  01 unmapped, 10 timeout
- err_addr_o  out  ADDR_W  address of the first captured error
- err_clr_i  in  1  clears sticky error state

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - state=IDLE
  - all outputs 0: s_valid_o, m_ready_o, m_err_o, m_rdata_o, s_addr/wdata/wstrb, err_vld_o, err_code_o, err_addr_o
  - timeout counter 0
- Reset mid-transaction aborts immediately. No m_ready_o is issued; s_valid_o drops the next cycle.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE:
  - On m_valid_i, decode the hit vector; lowest-index hit wins on overlap.
  - Register addr/wdata/wstrb and the one-hot select.
  - If any slave hits, go to BUSY and assert s_valid_o[sel] the next cycle.
  - If no slave hits, go to ERR.
- BUSY:
  - s_valid_o[sel] held and the counter increments each cycle.
  - s_ready_i of non-selected slaves is ignored.
  - On s_ready_i[sel], capture s_rdata_i[sel] into m_rdata_o, drop s_valid_o, and go to RESP.
  - If the counter reaches TIMEOUT (and TIMEOUT≠0) with no ready, drop s_valid_o, load ERR_RDATA, set the timeout error, and go to RESP with m_err_o=1.
  - If ready and timeout occur in the same cycle, ready wins.
- ERR: load m_rdata_o=ERR_RDATA, set the unmapped error, go to RESP with m_err_o=1.
- RESP:
  - m_ready_o=1 for exactly one cycle, m_err_o as set; then go to IDLE and clear the counter.
  - m_rdata_o holds its value until the next capture.
- Latency:
  - mapped access = slave latency + 2 cycles (decode register + response register); a slave ready in its first valid cycle gives m_ready_o 3 cycles after m_valid_i rises.
  - unmapped access = m_ready_o 2 cycles after m_valid_i.
- Master protocol:
  - m_valid_i and its payload are stable until m_ready_o.
  - m_valid_i is low in the cycle after m_ready_o; the block does not sample m_valid_i in RESP.
- Sticky error capture:
  - On the first error with err_vld_o=0, set err_vld_o and latch err_code_o and err_addr_o. Later errors do not overwrite.
  - err_clr_i clears all three next cycle. If clear and a new error coincide, the new error is captured.
- A late s_ready_i after timeout, arriving in IDLE, is ignored.
- Only one outstanding transaction at a time.

Decomposition:
- Package nmi_dec_pkg:
  - state enum (IDLE, BUSY, RESP, ERR)
  - err_code typedef with constants ERR_NONE=2'b00, ERR_UNMAP=2'b01, ERR_TMO=2'b10
  - function for lowest-index one-hot priority select
- Sub-module nmi_addr_match: combinational base/mask compare producing the NUM_SLV hit vector plus an any_hit flag. It is reused by the future DMA-side decoder.

Test Plan:
- NUM_SLV=4, slave1 base 0x1000_1000 mask 0xFF00_FF00, ready in first valid cycle, rdata 0xA5A5_0001; read 0x1000_1004 -> s_valid_o=4'b0010 one cycle, m_ready_o 3 cycles after request, m_rdata_o=0xA5A5_0001, m_err_o=0.
- Write 0x1000_1008 with wdata 0x1234_5678 and wstrb 4'hF, slave ready after 5 wait cycles -> s_wdata_o=0x1234_5678 held stable throughout, single m_ready_o pulse.
- Read unmapped 0x2000_0000 -> no s_valid_o, m_ready_o after 2 cycles, m_err_o=1, rdata 0xDEAD_BEEF, err_vld_o=1, err_code_o=01, err_addr_o=0x2000_0000.
- TIMEOUT=8, slave never ready -> s_valid_o drops after 8 BUSY cycles, m_err_o=1, err_code_o stays 01 (first error retained); after err_clr_i, repeat -> err_code_o=10.
- Overlapping map with slaves 0 and 2 both hitting -> only s_valid_o[0] asserted.
- Assert rst_i during BUSY -> next cycle s_valid_o=0, no m_ready_o, state IDLE; a following read completes normally.

Source files
------------

// File: rtl/nmi_dec_pkg.sv
// Shared types and helpers for the registered NMI address decoder.
//   state_t      : transaction FSM states
//   err_code_t   : sticky error code encoding
//   prio_onehot  : keeps only the lowest set bit of a request vector
package nmi_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_ERR
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE  = 2'b00;
    localparam err_code_t ERR_UNMAP = 2'b01;
    localparam err_code_t ERR_TMO   = 2'b10;

    localparam int unsigned MAX_SLV = 32;

    // Two's-complement trick: v & -v isolates the lowest set bit.
    function automatic logic [MAX_SLV-1:0] prio_onehot(input logic [MAX_SLV-1:0] v);
        return v & (~v + MAX_SLV'(1));
    endfunction

endpackage

// File: rtl/nmi_addr_match.sv
// Combinational base/mask address compare.
//   i_addr    : address to decode
//   o_hit     : one bit per slave, set when (addr & MASK_i) == BASE_i
//   o_any_hit : at least one slave matched
module nmi_addr_match #(
    parameter int unsigned               NUM_SLV  = 12,
    parameter int unsigned               ADDR_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_hit,
    output logic               o_any_hit
);

    always_comb begin
        o_hit = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            o_hit[i] = ((i_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
        end
        o_any_hit = |o_hit;
    end

endmodule

// File: rtl/nmi_dec_n.sv
// Registered NMI decoder: one master port fanned out to NUM_SLV slaves.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   m_valid_i/addr/wdata/wstrb : master request (wstrb == 0 means read)
//   m_ready_o, m_rdata_o, m_err_o : one-cycle registered response
//   s_valid_o              : one-hot slave request
//   s_addr/wdata/wstrb_o   : registered broadcast payload
//   s_ready_i, s_rdata_i   : per-slave response (rdata packed)
//   err_vld_o/code_o/addr_o, err_clr_i : sticky first-error capture
// Unmapped accesses and slave timeouts complete with m_err_o and ERR_RDATA.
module nmi_dec_n
    import nmi_dec_pkg::*;
#(
    parameter int unsigned               NUM_SLV   = 12,
    parameter int unsigned               ADDR_W    = 32,
    parameter int unsigned               DATA_W    = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE  = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK  = '0,
    parameter int unsigned               TIMEOUT   = 1023,
    parameter logic [DATA_W-1:0]         ERR_RDATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      m_valid_i,
    input  logic [ADDR_W-1:0]         m_addr_i,
    input  logic [DATA_W-1:0]         m_wdata_i,
    input  logic [DATA_W/8-1:0]       m_wstrb_i,
    output logic                      m_ready_o,
    output logic [DATA_W-1:0]         m_rdata_o,
    output logic                      m_err_o,
    output logic [NUM_SLV-1:0]        s_valid_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    output logic [DATA_W/8-1:0]       s_wstrb_o,
    input  logic [NUM_SLV-1:0]        s_ready_i,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata_i,
    output logic                      err_vld_o,
    output logic [1:0]                err_code_o,
    output logic [ADDR_W-1:0]         err_addr_o,
    input  logic                      err_clr_i
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [NUM_SLV-1:0]   w_hit;
    logic                 w_any_hit;
    logic [NUM_SLV-1:0]   w_sel;
    logic [NUM_SLV-1:0]   r_sel;
    logic [NUM_SLV-1:0]   r_svalid;

    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W/8-1:0]  r_wstrb;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;
    logic [DATA_W-1:0]    w_rdata_sel;

    logic [31:0]          r_cnt;
    logic [31:0]          w_cnt_inc;
    logic                 w_ready;
    logic                 w_tmo;

    logic                 w_err_evt;
    err_code_t            w_err_code;
    logic                 r_err_vld;
    err_code_t            r_err_code;
    logic [ADDR_W-1:0]    r_err_addr;

    nmi_addr_match #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .i_addr    (m_addr_i),
        .o_hit     (w_hit),
        .o_any_hit (w_any_hit)
    );

    assign w_sel = NUM_SLV'(prio_onehot(MAX_SLV'(w_hit)));

    // Ready only counts while our own registered valid is out, which also
    // masks non-selected slaves and any stray ready seen outside BUSY.
    assign w_ready   = |(s_ready_i & r_svalid);
    assign w_cnt_inc = r_cnt + 32'd1;
    assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == TIMEOUT);

    always_comb begin
        w_rdata_sel = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (r_sel[i]) begin
                w_rdata_sel = w_rdata_sel | s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_err_evt  = 1'b0;
        w_err_code = ERR_NONE;
        if (r_state == ST_ERR) begin
            w_err_evt  = 1'b1;
            w_err_code = ERR_UNMAP;
        end else if (r_state == ST_BUSY && !w_ready && w_tmo) begin
            w_err_evt  = 1'b1;
            w_err_code = ERR_TMO;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m_valid_i) begin
                    w_state_nxt = w_any_hit ? ST_BUSY : ST_ERR;
                end
            end
            ST_BUSY: begin
                if (w_ready || w_tmo) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_ERR:  w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sel      <= '0;
            r_svalid   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_err_vld  <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_addr <= '0;
        end else begin
            // Valid lags BUSY entry by one cycle: the decode result is
            // registered first, then driven to the slave.
            r_svalid <= (r_state == ST_BUSY && w_state_nxt == ST_BUSY) ? r_sel : '0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (m_valid_i) begin
                        r_addr  <= m_addr_i;
                        r_wdata <= m_wdata_i;
                        r_wstrb <= m_wstrb_i;
                        r_sel   <= w_sel;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (w_ready) begin
                        r_rdata <= w_rdata_sel;
                        r_err   <= 1'b0;
                    end else if (w_tmo) begin
                        r_rdata <= ERR_RDATA;
                        r_err   <= 1'b1;
                    end
                end
                ST_ERR: begin
                    r_rdata <= ERR_RDATA;
                    r_err   <= 1'b1;
                end
                ST_RESP: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
                default: ;
            endcase

            // A new error wins over a simultaneous clear.
            if (w_err_evt && (!r_err_vld || err_clr_i)) begin
                r_err_vld  <= 1'b1;
                r_err_code <= w_err_code;
                r_err_addr <= r_addr;
            end else if (err_clr_i) begin
                r_err_vld  <= 1'b0;
                r_err_code <= ERR_NONE;
                r_err_addr <= '0;
            end
        end
    end

    // Outputs
    always_comb begin
        m_ready_o  = (r_state == ST_RESP);
        m_err_o    = r_err;
        m_rdata_o  = r_rdata;
        s_valid_o  = r_svalid;
        s_addr_o   = r_addr;
        s_wdata_o  = r_wdata;
        s_wstrb_o  = r_wstrb;
        err_vld_o  = r_err_vld;
        err_code_o = r_err_code;
        err_addr_o = r_err_addr;
    end

endmodule

// File: tb/tb_nmi_dec_n.sv
// Directed bench for nmi_dec_n with a 4-slave map and TIMEOUT=8.
//   slave0 0x3000_xxxx, slave1 0x10xx_10xx, slave2 0x3xxx_xxxx, slave3 0x4000_xxxx
//   slave3 never answers; slave0/2 overlap on 0x3000_xxxx.
module tb_nmi_dec_n;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         m_valid_i = 1'b0;
    logic [31:0]  m_addr_i = '0;
    logic [31:0]  m_wdata_i = '0;
    logic [3:0]   m_wstrb_i = '0;
    logic         m_ready_o;
    logic [31:0]  m_rdata_o;
    logic         m_err_o;
    logic [3:0]   s_valid_o;
    logic [31:0]  s_addr_o;
    logic [31:0]  s_wdata_o;
    logic [3:0]   s_wstrb_o;
    logic [3:0]   s_ready_i;
    logic [127:0] s_rdata_i;
    logic         err_vld_o;
    logic [1:0]   err_code_o;
    logic [31:0]  err_addr_o;
    logic         err_clr_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int wait_cyc[4] = '{0, 0, 0, 1000};
    int vcnt[4]     = '{default: 0};

    int          lat, svcnt, pay_bad;
    logic [31:0] rd;
    logic        er, ra;
    logic [3:0]  svor;

    assign s_rdata_i = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    nmi_dec_n #(
        .NUM_SLV   (4),
        .ADDR_W    (32),
        .DATA_W    (32),
        .SLV_BASE  ({32'h4000_0000, 32'h3000_0000, 32'h1000_1000, 32'h3000_0000}),
        .SLV_MASK  ({32'hFFFF_0000, 32'hF000_0000, 32'hFF00_FF00, 32'hFFFF_0000}),
        .TIMEOUT   (8),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .m_valid_i  (m_valid_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_wstrb_i  (m_wstrb_i),
        .m_ready_o  (m_ready_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_valid_o  (s_valid_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_wstrb_o  (s_wstrb_o),
        .s_ready_i  (s_ready_i),
        .s_rdata_i  (s_rdata_i),
        .err_vld_o  (err_vld_o),
        .err_code_o (err_code_o),
        .err_addr_o (err_addr_o),
        .err_clr_i  (err_clr_i)
    );

    always #5 clk = ~clk;

    // Slave model: ready after wait_cyc[i] cycles of continuous valid.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            vcnt[i] <= s_valid_o[i] ? vcnt[i] + 1 : 0;
        end
    end

    always_comb begin
        s_ready_i = '0;
        for (int i = 0; i < 4; i++) begin
            s_ready_i[i] = s_valid_o[i] && (vcnt[i] == wait_cyc[i]);
        end
    end

    // Drives one request and reports what the DUT did; latency is counted in
    // negedges after the negedge that raised m_valid_i (bounded to 40).
    task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int o_lat,
                           output logic [31:0] o_rd, output logic o_er,
                           output int o_svcnt, output logic [3:0] o_svor,
                           output int o_pay_bad, output logic o_ra);
        o_lat = -1; o_rd = 'x; o_er = 'x; o_svcnt = 0; o_svor = '0; o_pay_bad = 0;
        @(negedge clk);
        m_valid_i = 1'b1; m_addr_i = addr; m_wdata_i = wdata; m_wstrb_i = wstrb;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s_valid_o != 4'b0) begin
                o_svcnt++;
                o_svor = o_svor | s_valid_o;
                if (s_addr_o !== addr || s_wdata_o !== wdata || s_wstrb_o !== wstrb) o_pay_bad++;
            end
            if (m_ready_o === 1'b1) begin
                o_lat = k; o_rd = m_rdata_o; o_er = m_err_o;
                break;
            end
        end
        m_valid_i = 1'b0;
        @(negedge clk);
        o_ra = m_ready_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (s_valid_o !== 4'b0) begin n_bad++; $display("FAIL rst_svalid got %b exp 0000", s_valid_o); end
        n_cmp++; if (m_ready_o !== 1'b0 || m_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready_err got %b%b exp 00", m_ready_o, m_err_o); end
        n_cmp++; if (m_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h exp 0", m_rdata_o); end
        n_cmp++; if ({s_addr_o, s_wdata_o, s_wstrb_o} !== 68'h0) begin n_bad++; $display("FAIL rst_payload got %h %h %h exp 0", s_addr_o, s_wdata_o, s_wstrb_o); end
        n_cmp++; if (err_vld_o !== 1'b0 || err_code_o !== 2'b00 || err_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_err got %b %b %h exp 0", err_vld_o, err_code_o, err_addr_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_read();
        run_req(32'h1000_1004, 32'h0, 4'h0, lat, rd, er, svcnt, svor, pay_bad, ra);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency got %0d exp 3", lat); end
        n_cmp++; if (svor !== 4'b0010 || svcnt !== 1) begin n_bad++; $display("FAIL rd_svalid got %b x%0d exp 0010 x1", svor, svcnt); end
        n_cmp++; if (rd !== 32'hA5A5_0001 || er !== 1'b0) begin n_bad++; $display("FAIL rd_data got %h err %b exp a5a50001 err 0", rd, er); end
        n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL rd_single_pulse got %b exp 0", ra); end
        n_cmp++; if (err_vld_o !== 1'b0) begin n_bad++; $display("FAIL rd_no_err got %b exp 0", err_vld_o); end
    endtask

    task automatic test_write();
        wait_cyc[1] = 5;
        run_req(32'h1000_1008, 32'h1234_5678, 4'hF, lat, rd, er, svcnt, svor, pay_bad, ra);
        wait_cyc[1] = 0;
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL wr_latency got %0d exp 8", lat); end
        n_cmp++; if (svcnt !== 6 || svor !== 4'b0010) begin n_bad++; $display("FAIL wr_svalid got %b x%0d exp 0010 x6", svor, svcnt); end
        n_cmp++; if (pay_bad !== 0) begin n_bad++; $display("FAIL wr_payload_stable got %0d bad cycles exp 0", pay_bad); end
        n_cmp++; if (ra !== 1'b0 || er !== 1'b0) begin n_bad++; $display("FAIL wr_pulse got after=%b err=%b exp 0 0", ra, er); end
    endtask

    task automatic test_unmapped();
        run_req(32'h2000_0000, 32'h0, 4'h0, lat, rd, er, svcnt, svor, pay_bad, ra);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL um_latency got %0d exp 2", lat); end
        n_cmp++; if (svcnt !== 0) begin n_bad++; $display("FAIL um_svalid got %0d cycles exp 0", svcnt); end
        n_cmp++; if (er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL um_resp got err %b data %h exp 1 deadbeef", er, rd); end
        n_cmp++; if (err_vld_o !== 1'b1 || err_code_o !== 2'b01 || err_addr_o !== 32'h2000_0000) begin n_bad++; $display("FAIL um_sticky got %b %b %h exp 1 01 20000000", err_vld_o, err_code_o, err_addr_o); end
    endtask

    task automatic test_timeout();
        run_req(32'h4000_0000, 32'h0, 4'h0, lat, rd, er, svcnt, svor, pay_bad, ra);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL tmo_latency got %0d exp 9", lat); end
        n_cmp++; if (svcnt !== 7 || svor !== 4'b1000) begin n_bad++; $display("FAIL tmo_svalid got %b x%0d exp 1000 x7", svor, svcnt); end
        n_cmp++; if (er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL tmo_resp got err %b data %h exp 1 deadbeef", er, rd); end
        n_cmp++; if (err_code_o !== 2'b01 || err_addr_o !== 32'h2000_0000) begin n_bad++; $display("FAIL tmo_first_kept got %b %h exp 01 20000000", err_code_o, err_addr_o); end
        @(negedge clk); err_clr_i = 1'b1;
        @(negedge clk); err_clr_i = 1'b0;
        n_cmp++; if (err_vld_o !== 1'b0 || err_code_o !== 2'b00 || err_addr_o !== 32'h0) begin n_bad++; $display("FAIL clr got %b %b %h exp 0 00 0", err_vld_o, err_code_o, err_addr_o); end
        run_req(32'h4000_0004, 32'h0, 4'h0, lat, rd, er, svcnt, svor, pay_bad, ra);
        n_cmp++; if (lat !== 9 || er !== 1'b1) begin n_bad++; $display("FAIL tmo2_resp got lat %0d err %b exp 9 1", lat, er); end
        n_cmp++; if (err_vld_o !== 1'b1 || err_code_o !== 2'b10 || err_addr_o !== 32'h4000_0004) begin n_bad++; $display("FAIL tmo2_sticky got %b %b %h exp 1 10 40000004", err_vld_o, err_code_o, err_addr_o); end
    endtask

    task automatic test_overlap();
        run_req(32'h3000_0010, 32'h0, 4'h0, lat, rd, er, svcnt, svor, pay_bad, ra);
        n_cmp++; if (svor !== 4'b0001) begin n_bad++; $display("FAIL ovl_select got %b exp 0001", svor); end
        n_cmp++; if (rd !== 32'hA5A5_0000 || lat !== 3) begin n_bad++; $display("FAIL ovl_resp got %h lat %0d exp a5a50000 3", rd, lat); end
    endtask

    task automatic test_back_to_back();
        run_req(32'h3000_0020, 32'h0, 4'h0, lat, rd, er, svcnt, svor, pay_bad, ra);
        n_cmp++; if (rd !== 32'hA5A5_0000 || lat !== 3) begin n_bad++; $display("FAIL b2b_first got %h lat %0d exp a5a50000 3", rd, lat); end
        run_req(32'h1000_100C, 32'hCAFE_0001, 4'h3, lat, rd, er, svcnt, svor, pay_bad, ra);
        n_cmp++; if (rd !== 32'hA5A5_0001 || lat !== 3 || svor !== 4'b0010) begin n_bad++; $display("FAIL b2b_second got %h lat %0d sel %b exp a5a50001 3 0010", rd, lat, svor); end
        n_cmp++; if (pay_bad !== 0) begin n_bad++; $display("FAIL b2b_payload got %0d bad cycles exp 0", pay_bad); end
    endtask

    task automatic test_reset_busy();
        logic seen;
        @(negedge clk);
        m_valid_i = 1'b1; m_addr_i = 32'h4000_0000; m_wdata_i = '0; m_wstrb_i = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (s_valid_o !== 4'b1000) begin n_bad++; $display("FAIL rb_pre_svalid got %b exp 1000", s_valid_o); end
        rst_i = 1'b1; m_valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        n_cmp++; if (s_valid_o !== 4'b0 || m_ready_o !== 1'b0) begin n_bad++; $display("FAIL rb_abort got svalid %b ready %b exp 0000 0", s_valid_o, m_ready_o); end
        n_cmp++; if (err_vld_o !== 1'b0) begin n_bad++; $display("FAIL rb_err_cleared got %b exp 0", err_vld_o); end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (m_ready_o !== 1'b0 || s_valid_o !== 4'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rb_quiet got activity %b exp 0", seen); end
        run_req(32'h1000_1004, 32'h0, 4'h0, lat, rd, er, svcnt, svor, pay_bad, ra);
        n_cmp++; if (lat !== 3 || rd !== 32'hA5A5_0001 || er !== 1'b0) begin n_bad++; $display("FAIL rb_after got lat %0d data %h err %b exp 3 a5a50001 0", lat, rd, er); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_overlap();
        test_back_to_back();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
